// File: rtl/pyramid_sequencer.sv
// Purpose: walks the octave/level job list of an image pyramid and launches blur/downsample jobs on an engine.
// Latency: start_in -> first job_start_out 1 cycle; job_done_in -> next job_start_out 2 cycles.
// Backpressure: one job outstanding at a time; the next job waits for job_done_in (optional watchdog SEQ_WATCHDOG_EN).
module pyramid_sequencer #(
    parameter int NUM_OCTAVES    = 3,
    parameter int NUM_LEVELS     = 3,
    parameter int TOP_WIDTH      = 64,
    parameter int TOP_HEIGHT     = 64,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                            clk_in,
    input  logic                            rst_n_in,
    input  logic                            start_in,
    output logic                            busy_out,
    output logic                            pyramid_done,
    output logic                            error_out,
    output logic                            job_start_out,
    output logic                            job_op_out,
    output logic [1:0]                      job_octave_out,
    output logic [1:0]                      job_level_out,
    output logic                            job_src_ext_out,
    output logic [$clog2(TOP_WIDTH):0]      job_width_out,
    output logic [$clog2(TOP_HEIGHT):0]     job_height_out,
    input  logic                            job_done_in
);

    localparam int WW = $clog2(TOP_WIDTH) + 1;
    localparam int HW = $clog2(TOP_HEIGHT) + 1;

    localparam logic [1:0]    LAST_OCT = 2'(NUM_OCTAVES - 1);
    localparam logic [1:0]    LAST_LVL = 2'(NUM_LEVELS - 1);
    localparam logic [WW-1:0] TOP_W    = WW'(TOP_WIDTH);
    localparam logic [HW-1:0] TOP_H    = HW'(TOP_HEIGHT);

    localparam logic OP_BLUR       = 1'b0;
    localparam logic OP_DOWNSAMPLE = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        NEXT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state;
    logic [1:0]      octave;
    logic [1:0]      level;
    logic            op_q;
    logic            ext_q;
    logic [WW-1:0]   width_q;
    logic [HW-1:0]   height_q;
    logic            start_q;
    logic            busy_q;
    logic            done_q;

    logic            lvl_wrap;
    logic            last_job;
    logic [1:0]      nxt_oct;
    logic [1:0]      nxt_lvl;

`ifdef SEQ_WATCHDOG_EN
    localparam int             WDW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

    logic            err_q;
    logic [WDW-1:0]  wd_cnt;
`endif

    // Position of the job that follows the current one; a level wrap starts a new octave.
    always_comb begin
        lvl_wrap = (level == LAST_LVL);
        last_job = (octave == LAST_OCT) && lvl_wrap;
        nxt_lvl  = lvl_wrap ? 2'd0 : level + 2'd1;
        nxt_oct  = lvl_wrap ? octave + 2'd1 : octave;
    end

    // Sequencer FSM; every job field and status flag is registered here so outputs are glitch-free.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state    <= IDLE;
            octave   <= 2'd0;
            level    <= 2'd0;
            op_q     <= 1'b0;
            ext_q    <= 1'b0;
            width_q  <= '0;
            height_q <= '0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            err_q    <= 1'b0;
            wd_cnt   <= '0;
`endif
        end else begin
            // Launch and completion strobes are single-cycle pulses.
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        // Octave 0, level 0 blurs the external input image.
                        octave   <= 2'd0;
                        level    <= 2'd0;
                        op_q     <= OP_BLUR;
                        ext_q    <= 1'b1;
                        width_q  <= TOP_W;
                        height_q <= TOP_H;
                        start_q  <= 1'b1;
                        busy_q   <= 1'b1;
`ifdef SEQ_WATCHDOG_EN
                        err_q    <= 1'b0;
`endif
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A done pulse in the launch cycle cannot belong to this job; it is dropped.
`ifdef SEQ_WATCHDOG_EN
                    wd_cnt <= '0;
`endif
                    state  <= WAIT;
                end
                WAIT: begin
                    if (job_done_in) begin
                        if (last_job) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state  <= NEXT;
                        end
                    end
`ifdef SEQ_WATCHDOG_EN
                    else if (wd_cnt == WD_LAST) begin
                        // Engine stalled: abort but still report completion so the host is not left waiting.
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                NEXT: begin
                    // Level 0 of a new octave downsamples the last level of the previous octave;
                    // every other job blurs the level below it in the same octave.
                    octave   <= nxt_oct;
                    level    <= nxt_lvl;
                    op_q     <= lvl_wrap ? OP_DOWNSAMPLE : OP_BLUR;
                    ext_q    <= 1'b0;
                    width_q  <= TOP_W >> nxt_oct;
                    height_q <= TOP_H >> nxt_oct;
                    start_q  <= 1'b1;
                    state    <= ISSUE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy_out        = busy_q;
    assign pyramid_done    = done_q;
    assign job_start_out   = start_q;
    assign job_op_out      = op_q;
    assign job_octave_out  = octave;
    assign job_level_out   = level;
    assign job_src_ext_out = ext_q;
    assign job_width_out   = width_q;
    assign job_height_out  = height_q;

`ifdef SEQ_WATCHDOG_EN
    assign error_out = err_q;
`else
    assign error_out = 1'b0;
`endif

endmodule

// File: doc/pyramid_sequencer.md
PYRAMID_SEQUENCER -- requirements
Module: pyramid_sequencer

Interface
REQ-001 The block SHALL expose parameter NUM_OCTAVES, default 3, the number of octaves sequenced (1..4).
REQ-002 The block SHALL expose parameter NUM_LEVELS, default 3, the number of blur levels per octave (1..4).
REQ-003 The block SHALL expose parameters TOP_WIDTH and TOP_HEIGHT, default 64 each, the octave-0 image dimensions.
REQ-004 The block SHALL expose parameter TIMEOUT_CYCLES, default 100000, the watchdog limit.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-006 The ports SHALL be as follows:
- clk_in, input, 1: the single clock.
- rst_n_in, input, 1: asynchronous active-low reset.
- start_in, input, 1: begin a pyramid build.
- busy_out, output, 1: build in progress.
- pyramid_done, output, 1: one-cycle pulse when the build ends.
- error_out, output, 1: watchdog abort flag.
- job_start_out, output, 1: one-cycle pulse that launches an engine job.
- job_op_out, output, 1: engine operation; 0 = BLUR, 1 = DOWNSAMPLE.
- job_octave_out, output, 2: destination octave.
- job_level_out, output, 2: destination level.
- job_src_ext_out, output, 1: 1 = source is the external image.
- job_width_out, output, $clog2(TOP_WIDTH)+1: destination width.
- job_height_out, output, $clog2(TOP_HEIGHT)+1: destination height.
- job_done_in, input, 1: engine job-complete pulse.

Function
REQ-007 The FSM SHALL have states IDLE, ISSUE, WAIT, NEXT and DONE.
REQ-008 In IDLE, start_in=1 at a clock edge SHALL load octave=0 and level=0 and move to ISSUE; start_in SHALL be ignored in every other state.
REQ-009 In ISSUE, job_start_out SHALL be 1 for exactly that cycle, and the FSM SHALL then move to WAIT.
REQ-010 All job_* fields SHALL be registered, valid in ISSUE, and held stable through WAIT and NEXT.
REQ-011 The job list SHALL be generated as follows:
- (0,0): BLUR with src_ext=1.
- (o>0, 0): DOWNSAMPLE of (o-1, NUM_LEVELS-1).
- (o, l>0): BLUR of (o, l-1).
- src_ext SHALL be 0 for every job except (0,0).
REQ-012 job_width_out SHALL equal TOP_WIDTH>>octave, and job_height_out SHALL equal TOP_HEIGHT>>octave.
REQ-013 job_done_in SHALL be sampled only in WAIT; a pulse seen in any other state (including the ISSUE cycle) SHALL be ignored and SHALL NOT be remembered.
REQ-014 On job_done_in in WAIT, the FSM SHALL move to NEXT, or to DONE if the job was (NUM_OCTAVES-1, NUM_LEVELS-1).
REQ-015 In NEXT, level SHALL increment; if it wraps at NUM_LEVELS, it SHALL reset to 0 and octave SHALL increment. The FSM SHALL then move to ISSUE.
REQ-016 Latency from job_done_in to the next job_start_out SHALL be exactly 2 cycles.
REQ-017 Latency from start_in to the first job_start_out SHALL be 1 cycle.
REQ-018 In DONE, pyramid_done SHALL be 1 for one cycle, and the FSM SHALL return to IDLE.
REQ-019 busy_out SHALL be 1 in ISSUE, WAIT and NEXT, and 0 in IDLE and DONE.
REQ-020 With NUM_OCTAVES=1 and NUM_LEVELS=1, the block SHALL issue exactly one job and then reach DONE.
REQ-021 error_out SHALL be cleared on each accepted start_in and SHALL otherwise hold its value.

Reset
REQ-022 Asserting rst_n_in=0 SHALL immediately, without waiting for a clock edge, force:
- state = IDLE;
- octave = 0 and level = 0;
- all outputs = 0.
REQ-023 Reset asserted mid-build SHALL abandon the build, and no pyramid_done SHALL be issued for it.
REQ-024 Reset deassertion SHALL take effect on the first rising clk_in edge after rst_n_in rises.

Configuration
REQ-025 With SEQ_WATCHDOG_EN defined, a cycle counter SHALL run in WAIT and clear on entry to WAIT.
REQ-026 With SEQ_WATCHDOG_EN defined, if the counter reaches TIMEOUT_CYCLES without job_done_in, the FSM SHALL set error_out=1 and move to DONE, so pyramid_done still pulses.
REQ-027 Without SEQ_WATCHDOG_EN, the counter SHALL be absent, error_out SHALL be tied 0, and WAIT SHALL persist indefinitely.

Verification
REQ-028 Defaults; start_in pulse; engine answers job_done_in 5 cycles after each job_start_out -> exactly 9 jobs in the order (0,0)B ext, (0,1)B, (0,2)B, (1,0)D, (1,1)B, (1,2)B, (2,0)D, (2,1)B, (2,2)B; widths 64, 64, 64, 32, 32, 32, 16, 16, 16; one pyramid_done; error_out=0.
REQ-029 job_done_in pulsed in the ISSUE cycle and again 3 cycles later -> the first pulse is ignored, and the next job_start_out appears exactly 2 cycles after the second pulse.
REQ-030 start_in pulsed while in WAIT of job (1,1) -> no restart; the job sequence continues unchanged.
REQ-031 rst_n_in=0 asserted mid-cycle during job (0,2) -> all outputs go to 0 before the next edge; no pyramid_done; a new start_in after release begins again at (0,0).
REQ-032 SEQ_WATCHDOG_EN defined, TIMEOUT_CYCLES=20, engine never answers job (0,0) -> error_out=1 and pyramid_done pulse 21-22 cycles after job_start_out; busy_out=0 afterwards.
REQ-033 NUM_OCTAVES=1, NUM_LEVELS=1 -> a single BLUR job with src_ext=1, then pyramid_done.
